// File: rtl/display_pkg.sv
// Shared display constants and helpers for the multiplexed 7-segment scanner.
// Contents: digit/segment widths, the blank segment pattern, the scan-state
// enum (one state per digit position) and the leading-zero blanking helper.
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int SEG_W      = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_state_e;

  // True when digit idx (idx >= 1) and every more significant digit is zero.
  // Digit 0 always stays lit so an all-zero value still shows "0".
  function automatic logic lz_blank(input logic [NUM_DIGITS*DIGIT_W-1:0] disp,
                                    input logic [1:0] idx);
    logic all_zero;
    all_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && disp[DIGIT_W*i +: DIGIT_W] != 4'h0)
        all_zero = 1'b0;
    end
    return (idx != 2'd0) && all_zero;
  endfunction

endpackage

// File: rtl/display_scan_if.sv
// Value handshake between a producer and the display scanner.
//   value_i : four BCD nibbles, [3:0] is digit 0
//   valid_i : value_i is offered
//   ready_o : scanner's pending slot is free; transfer on valid_i && ready_o
interface display_scan_if;
  import display_pkg::*;

  logic [NUM_DIGITS*DIGIT_W-1:0] value_i;
  logic                          valid_i;
  logic                          ready_o;

  modport master (output value_i, output valid_i, input  ready_o);
  modport slave  (input  value_i, input  valid_i, output ready_o);

endinterface

// File: rtl/display_scan_sev_seg.sv
// sev_seg: BCD to active-low 7-segment decoder, seg[6]=segA .. seg[0]=segG.
//   data : BCD nibble
//   seg  : segment pattern; non-BCD codes decode to all segments off
module sev_seg
  import display_pkg::*;
(
  input  logic [DIGIT_W-1:0] data,
  output logic [SEG_W-1:0]   seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (data)
      4'd0: seg = 7'b0000001;
      4'd1: seg = 7'b1001111;
      4'd2: seg = 7'b0010010;
      4'd3: seg = 7'b0000110;
      4'd4: seg = 7'b1001100;
      4'd5: seg = 7'b0100100;
      4'd6: seg = 7'b0100000;
      4'd7: seg = 7'b0001111;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// display_scan: time-multiplexed 4-digit 7-segment driver with a one-deep
// pending slot so new values only take effect at frame boundaries.
//
//   state | meaning
//   DIG0  | digit 0 is being driven
//   DIG1  | digit 1 is being driven
//   DIG2  | digit 2 is being driven
//   DIG3  | digit 3 is being driven; its last cycle is the frame boundary
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : value/valid/ready handshake (slave side)
//   blank_lz_i  : leading-zero blanking enable
//   digit_o     : BCD nibble of the scanned digit
//   seg_o       : active-low segments, [6]=segA
//   an_o        : active-low digit enables
//   frame_o     : pulse on the last cycle of each full scan
module display_scan
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_scan_if.slave        bus,
  input  logic                 blank_lz_i,
  output logic [DIGIT_W-1:0]   digit_o,
  output logic [SEG_W-1:0]     seg_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic                 frame_o
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0]                  pre;
  scan_state_e                    state, state_nxt;
  logic [1:0]                     idx;
  logic [NUM_DIGITS*DIGIT_W-1:0]  disp;
  logic [NUM_DIGITS*DIGIT_W-1:0]  pend;
  logic                           pend_vld;
  logic                           pre_wrap;
  logic                           boundary;
  logic                           xfer;
  logic [SEG_W-1:0]               seg_raw;
  logic                           blank;

  assign pre_wrap = (pre == PRE_LAST);
  assign idx      = state;
  assign boundary = pre_wrap && (state == DIG3);
  assign frame_o  = boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pre <= '0;
    else if (pre_wrap)
      pre <= '0;
    else
      pre <= pre + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= DIG0;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    an_o      = '1;
    if (pre_wrap) begin
      case (state)
        DIG0:    state_nxt = DIG1;
        DIG1:    state_nxt = DIG2;
        DIG2:    state_nxt = DIG3;
        DIG3:    state_nxt = DIG0;
        default: state_nxt = DIG0;
      endcase
    end
    // First cycle of each digit is a guard with all anodes off to avoid ghosting.
    if (pre != '0)
      an_o[idx] = 1'b0;
  end

  // pend_vld is set only when ready, so a boundary copy and a new capture
  // never coincide; a capture on the boundary cycle waits a full frame.
  assign bus.ready_o = !pend_vld;
  assign xfer        = bus.valid_i && bus.ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp     <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
    end else if (boundary && pend_vld) begin
      disp     <= pend;
      pend_vld <= 1'b0;
    end else if (xfer) begin
      pend     <= bus.value_i;
      pend_vld <= 1'b1;
    end
  end

  assign digit_o = disp[{idx, 2'b00} +: DIGIT_W];

  sev_seg u_sev_seg (
    .data (digit_o),
    .seg  (seg_raw)
  );

  assign blank = (digit_o > 4'd9) || (blank_lz_i && lz_blank(disp, idx));
  assign seg_o = blank ? SEG_BLANK : seg_raw;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with REFRESH_DIV=4 (16-cycle frames).
// Cycle numbers count from reset release; cycle c drives digit (c/4)%4 and
// is a guard cycle when c%4==0. Outputs are sampled at the falling edge.
module tb_display_scan;
  import display_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       blank_lz_i = 1'b0;
  logic [3:0] digit_o;
  logic [6:0] seg_o;
  logic [3:0] an_o;
  logic       frame_o;

  display_scan_if bus ();

  display_scan #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .blank_lz_i (blank_lz_i),
    .digit_o    (digit_o),
    .seg_o      (seg_o),
    .an_o       (an_o),
    .frame_o    (frame_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] SB = 7'b1111111;

  function automatic logic [3:0] an_exp(input int c);
    logic [3:0] a;
    a = 4'hF;
    if (c % 4 != 0) a[(c / 4) % 4] = 1'b0;
    return a;
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] d, input int c);
    return d[4 * ((c / 4) % 4) +: 4];
  endfunction

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    bus.value_i = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.valid_i = 1'b1;
    bus.value_i = 16'h8888;
    repeat (6) next_cycle();
    bus.valid_i = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (an_o !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %b expected 1111", an_o); end
    n_tests++; if (frame_o !== 1'b0) begin n_fail++; $display("FAIL reset_frame: got %b expected 0", frame_o); end
    n_tests++; if (digit_o !== 4'h0) begin n_fail++; $display("FAIL reset_digit: got %h expected 0", digit_o); end
    n_tests++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.ready_o); end
    n_tests++; if (seg_o !== S0) begin n_fail++; $display("FAIL reset_seg: got %b expected %b", seg_o, S0); end
  endtask

  task automatic test_idle_scan();
    do_reset();
    blank_lz_i = 1'b0;
    while (cyc < 16) begin
      #1;
      n_tests++; if (an_o !== an_exp(cyc)) begin n_fail++; $display("FAIL idle_an c%0d: got %b expected %b", cyc, an_o, an_exp(cyc)); end
      n_tests++; if (frame_o !== (cyc == 15)) begin n_fail++; $display("FAIL idle_frame c%0d: got %b expected %b", cyc, frame_o, cyc == 15); end
      n_tests++; if (seg_o !== S0) begin n_fail++; $display("FAIL idle_seg c%0d: got %b expected %b", cyc, seg_o, S0); end
      next_cycle();
    end
  endtask

  task automatic test_transfer();
    logic [15:0] d;
    do_reset();
    while (cyc < 31) begin
      bus.valid_i = (cyc == 2) || (cyc >= 5 && cyc <= 7);
      bus.value_i = (cyc == 2) ? 16'h1234 : 16'hFFFF;
      #1;
      d = (cyc >= 16) ? 16'h1234 : 16'h0000;
      n_tests++; if (bus.ready_o !== !(cyc >= 3 && cyc <= 15)) begin n_fail++; $display("FAIL xfer_ready c%0d: got %b expected %b", cyc, bus.ready_o, !(cyc >= 3 && cyc <= 15)); end
      n_tests++; if (digit_o !== nib(d, cyc)) begin n_fail++; $display("FAIL xfer_digit c%0d: got %h expected %h", cyc, digit_o, nib(d, cyc)); end
      n_tests++; if (frame_o !== (cyc % 16 == 15)) begin n_fail++; $display("FAIL xfer_frame c%0d: got %b expected %b", cyc, frame_o, cyc % 16 == 15); end
      if (cyc >= 16 && (cyc / 4) % 4 == 2) begin
        n_tests++; if (seg_o !== S2) begin n_fail++; $display("FAIL xfer_seg2 c%0d: got %b expected %b", cyc, seg_o, S2); end
      end
      next_cycle();
    end
    bus.valid_i = 1'b0;
  endtask

  // Continues the timeline of test_transfer: 16'h1234 is on display.
  task automatic test_boundary_xfer();
    logic [15:0] d;
    while (cyc < 52) begin
      bus.valid_i = (cyc == 31);
      bus.value_i = 16'h0007;
      #1;
      if (cyc == 31) begin
        n_tests++; if (frame_o !== 1'b1 || bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL bnd_setup: got frame %b ready %b expected 1 1", frame_o, bus.ready_o); end
      end
      d = (cyc >= 48) ? 16'h0007 : 16'h1234;
      n_tests++; if (digit_o !== nib(d, cyc)) begin n_fail++; $display("FAIL bnd_digit c%0d: got %h expected %h", cyc, digit_o, nib(d, cyc)); end
      n_tests++; if (bus.ready_o !== !(cyc >= 32 && cyc <= 47)) begin n_fail++; $display("FAIL bnd_ready c%0d: got %b expected %b", cyc, bus.ready_o, !(cyc >= 32 && cyc <= 47)); end
      next_cycle();
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic test_blank();
    logic [6:0] s;
    int         i;
    do_reset();
    while (cyc < 64) begin
      bus.valid_i = (cyc == 0) || (cyc == 32);
      bus.value_i = (cyc == 0) ? 16'h0070 : 16'hA000;
      blank_lz_i  = !(cyc >= 32 && cyc < 48);
      #1;
      i = (cyc / 4) % 4;
      if (cyc < 16)       s = (i == 0) ? S0 : SB;
      else if (cyc < 32)  s = (i == 0) ? S0 : (i == 1) ? S7 : SB;
      else if (cyc < 48)  s = (i == 1) ? S7 : S0;
      else                s = (i == 3) ? SB : S0;
      n_tests++; if (seg_o !== s) begin n_fail++; $display("FAIL blank_seg c%0d: got %b expected %b", cyc, seg_o, s); end
      n_tests++; if (an_o !== an_exp(cyc)) begin n_fail++; $display("FAIL blank_an c%0d: got %b expected %b", cyc, an_o, an_exp(cyc)); end
      if (cyc >= 61) begin
        n_tests++; if (an_o !== 4'b0111 || digit_o !== 4'hA) begin n_fail++; $display("FAIL blank_hexA c%0d: got an %b digit %h expected 0111 a", cyc, an_o, digit_o); end
      end
      next_cycle();
    end
    bus.valid_i = 1'b0;
    blank_lz_i  = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    do_reset();
    while (cyc < 35) begin
      bus.valid_i = (cyc == 0) || (cyc == 32);
      bus.value_i = (cyc == 0) ? 16'h0007 : 16'h5555;
      #1;
      d = (cyc >= 16) ? 16'h0007 : 16'h0000;
      n_tests++; if (digit_o !== nib(d, cyc)) begin n_fail++; $display("FAIL rmid_digit c%0d: got %h expected %h", cyc, digit_o, nib(d, cyc)); end
      if (cyc == 34) begin
        n_tests++; if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL rmid_pending: got ready %b expected 0", bus.ready_o); end
        bus.valid_i = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++; if (an_o !== 4'hF) begin n_fail++; $display("FAIL rmid_an: got %b expected 1111", an_o); end
        n_tests++; if (frame_o !== 1'b0) begin n_fail++; $display("FAIL rmid_frame: got %b expected 0", frame_o); end
        n_tests++; if (digit_o !== 4'h0) begin n_fail++; $display("FAIL rmid_digit_rst: got %h expected 0", digit_o); end
        n_tests++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", bus.ready_o); end
        n_tests++; if (seg_o !== S0) begin n_fail++; $display("FAIL rmid_seg: got %b expected %b", seg_o, S0); end
      end
      next_cycle();
    end
    bus.valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 36) begin
      #1;
      n_tests++; if (digit_o !== 4'h0) begin n_fail++; $display("FAIL rmid_after_digit c%0d: got %h expected 0", cyc, digit_o); end
      n_tests++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_after_ready c%0d: got %b expected 1", cyc, bus.ready_o); end
      n_tests++; if (an_o !== an_exp(cyc)) begin n_fail++; $display("FAIL rmid_after_an c%0d: got %b expected %b", cyc, an_o, an_exp(cyc)); end
      next_cycle();
    end
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.value_i = 16'h0000;
    test_reset();
    test_idle_scan();
    test_transfer();
    test_boundary_xfer();
    test_blank();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
